// File: rtl/rvb_pkg.sv
// Shared constants and types for the bitmanip dispatch stages.
// Covers the opcode and function fields of the CLMUL family and the per-entry control bits.
package rvb_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OP32  = 7'b0111011;
   localparam logic [6:0] F7_CLMUL  = 7'b0000101;
   localparam logic [2:0] F3_CLMUL  = 3'b001;
   localparam logic [2:0] F3_CLMULR = 3'b010;
   localparam logic [2:0] F3_CLMULH = 3'b011;

   // Control part of a dispatch FIFO entry; operands and tag are appended by the user.
   typedef struct packed {
      logic legal;
      logic insn3;
      logic insn12;
      logic insn13;
   } clmul_ctl_t;

   function automatic logic clmul_legal(
      input logic [6:0] funct7,
      input logic [2:0] funct3,
      input logic [6:0] opcode,
      input logic       rv64
   );
      logic f3_ok;
      logic opc_ok;
      f3_ok  = (funct3 == F3_CLMUL) || (funct3 == F3_CLMULR) || (funct3 == F3_CLMULH);
      opc_ok = (opcode == OPC_OP) || (rv64 && (opcode == OPC_OP32));
      return (funct7 == F7_CLMUL) && f3_ok && opc_ok;
   endfunction

endpackage

// File: rtl/rvb_clmul.sv
// Iterative carry-less multiplier: 8 multiplier bits per cycle, so 4 cycles for 32-bit
// operands and 8 for 64-bit; a new op may load in the cycle the previous result is taken.
module rvb_clmul #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            din_valid,
   output logic            din_ready,
   input  logic            din_insn3,
   input  logic            din_insn12,
   input  logic            din_insn13,
   input  logic [XLEN-1:0] din_rs1,
   input  logic [XLEN-1:0] din_rs2,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic [XLEN-1:0] dout_rd
);

   localparam int PW = 2 * XLEN;

   logic            busy_reg;
   logic [3:0]      cnt_reg;
   logic [PW-1:0]   a_reg;
   logic [PW-1:0]   prod_reg;
   logic [XLEN-1:0] b_reg;
   logic            w_reg;
   logic            f12_reg;
   logic            f13_reg;
   logic [PW-1:0]   prod_next;
   logic [31:0]     w_res;
   logic [XLEN-1:0] x_res;
   logic            w_eff;
   logic            load;

   assign w_eff      = (XLEN == 32) || din_insn3;
   assign dout_valid = busy_reg && (cnt_reg == 4'd0);
   assign din_ready  = !reset && (!busy_reg || (dout_valid && dout_ready));
   assign load       = din_valid && din_ready;

   always_comb begin
      prod_next = prod_reg;
      for (int j = 0; j < 8; j++) begin
         if (b_reg[j]) begin
            prod_next = prod_next ^ (a_reg << j);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_reg <= 1'b0;
         cnt_reg  <= 4'd0;
         a_reg    <= '0;
         b_reg    <= '0;
         prod_reg <= '0;
         w_reg    <= 1'b0;
         f12_reg  <= 1'b0;
         f13_reg  <= 1'b0;
      end else if (load) begin
         busy_reg <= 1'b1;
         cnt_reg  <= w_eff ? 4'd4 : 4'd8;
         a_reg    <= PW'(w_eff ? XLEN'(din_rs1[31:0]) : din_rs1);
         b_reg    <= w_eff ? XLEN'(din_rs2[31:0]) : din_rs2;
         prod_reg <= '0;
         w_reg    <= w_eff;
         f12_reg  <= din_insn12;
         f13_reg  <= din_insn13;
      end else if (busy_reg && (cnt_reg != 4'd0)) begin
         prod_reg <= prod_next;
         a_reg    <= a_reg << 8;
         b_reg    <= b_reg >> 8;
         cnt_reg  <= cnt_reg - 4'd1;
      end else if (dout_valid && dout_ready) begin
         busy_reg <= 1'b0;
      end
   end

   // {insn13,insn12}: 01 low half, 10 reversed (bits 2w-2..w-1), 11 high half.
   always_comb begin
      case ({f13_reg, f12_reg})
         2'b10:   w_res = prod_reg[62:31];
         2'b11:   w_res = prod_reg[63:32];
         default: w_res = prod_reg[31:0];
      endcase
      case ({f13_reg, f12_reg})
         2'b10:   x_res = prod_reg[PW-2:XLEN-1];
         2'b11:   x_res = prod_reg[PW-1:XLEN];
         default: x_res = prod_reg[XLEN-1:0];
      endcase
      dout_rd = w_reg ? XLEN'($signed(w_res)) : x_res;
   end

endmodule

// File: rtl/rvb_fifo2.sv
// Generic two-entry valid/ready FIFO with registered storage.
// Accepts a push and a pop in the same cycle; push_ready is held low during reset.
module rvb_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   logic [WIDTH-1:0] mem_reg [2];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       count_reg;
   logic             push;
   logic             pop;

   assign push_ready = (count_reg != 2'd2) && !reset;
   assign pop_valid  = (count_reg != 2'd0);
   assign pop_data   = mem_reg[rd_ptr_reg];
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready;

   always_ff @(posedge clock) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr_reg <= !wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= !rd_ptr_reg;
         end
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/rvb_clmul_dispatch.sv
// CLMUL-family decode and dispatch in front of rvb_clmul: 2-entry input FIFO, single
// in-flight tag tracker, and an output mux that retires illegal ops in program order.
module rvb_clmul_dispatch
   import rvb_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int TAGW = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_insn,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [TAGW-1:0] in_tag,
   output logic            cm_valid,
   input  logic            cm_ready,
   output logic [XLEN-1:0] cm_rs1,
   output logic [XLEN-1:0] cm_rs2,
   output logic            cm_insn3,
   output logic            cm_insn12,
   output logic            cm_insn13,
   input  logic            cm_dout_valid,
   output logic            cm_dout_ready,
   input  logic [XLEN-1:0] cm_dout_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rd,
   output logic [TAGW-1:0] out_tag,
   output logic            out_illegal
);

   typedef struct packed {
      clmul_ctl_t      ctl;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [TAGW-1:0] tag;
   } entry_t;

   entry_t          in_entry;
   entry_t          head;
   logic            head_valid;
   logic            fifo_pop;
   logic            issue;
   logic            ill_valid;
   logic            result_accept;
   logic            pend_reg;
   logic [TAGW-1:0] pend_tag_reg;
   logic            unused_insn;

   // Register-index fields do not affect decode.
   assign unused_insn = ^{in_insn[24:15], in_insn[11:7]};

   always_comb begin
      in_entry.ctl.legal  = clmul_legal(in_insn[31:25], in_insn[14:12], in_insn[6:0], XLEN == 64);
      in_entry.ctl.insn3  = in_insn[3];
      in_entry.ctl.insn12 = in_insn[12];
      in_entry.ctl.insn13 = in_insn[13];
      in_entry.rs1        = in_rs1;
      in_entry.rs2        = in_rs2;
      in_entry.tag        = in_tag;
   end

   rvb_fifo2 #(
      .WIDTH($bits(entry_t))
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_valid(in_valid),
      .push_ready(in_ready),
      .push_data (in_entry),
      .pop_valid (head_valid),
      .pop_ready (fifo_pop),
      .pop_data  (head)
   );

   // An illegal head only retires once the multiplier is drained, preserving order.
   always_comb begin
      cm_valid      = !reset && head_valid && head.ctl.legal;
      issue         = cm_valid && cm_ready;
      ill_valid     = !reset && head_valid && !head.ctl.legal && !pend_reg;
      cm_dout_ready = !reset && pend_reg && out_ready;
      result_accept = cm_dout_ready && cm_dout_valid;
      fifo_pop      = issue || (ill_valid && out_ready);

      cm_rs1    = '0;
      cm_rs2    = '0;
      cm_insn3  = 1'b0;
      cm_insn12 = 1'b0;
      cm_insn13 = 1'b0;
      if (head_valid) begin
         cm_rs1    = head.rs1;
         cm_rs2    = head.rs2;
         cm_insn3  = head.ctl.insn3;
         cm_insn12 = head.ctl.insn12;
         cm_insn13 = head.ctl.insn13;
      end

      if (pend_reg) begin
         out_valid   = !reset && cm_dout_valid;
         out_rd      = cm_dout_rd;
         out_tag     = pend_tag_reg;
         out_illegal = 1'b0;
      end else begin
         out_valid   = ill_valid;
         out_rd      = '0;
         out_tag     = head_valid ? head.tag : '0;
         out_illegal = ill_valid;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_reg     <= 1'b0;
         pend_tag_reg <= '0;
      end else if (issue) begin
         pend_reg     <= 1'b1;
         pend_tag_reg <= head.tag;
      end else if (result_accept) begin
         pend_reg     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rvb_clmul_dispatch.sv
// Directed bench for rvb_clmul_dispatch with the rvb_clmul multiplier, XLEN=64 and XLEN=32.
module tb_rvb_clmul_dispatch;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // XLEN=64 instance signals
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_insn = '0;
   logic [63:0] in_rs1 = '0;
   logic [63:0] in_rs2 = '0;
   logic [4:0]  in_tag = '0;
   logic        cm_valid, cm_ready, cm_insn3, cm_insn12, cm_insn13;
   logic [63:0] cm_rs1, cm_rs2, cm_dout_rd;
   logic        cm_dout_valid, cm_dout_ready;
   logic        out_valid, out_illegal;
   logic        out_ready = 1'b1;
   logic [63:0] out_rd;
   logic [4:0]  out_tag;

   // XLEN=32 instance signals
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [31:0] s_in_insn = '0;
   logic [31:0] s_in_rs1 = '0;
   logic [31:0] s_in_rs2 = '0;
   logic [4:0]  s_in_tag = '0;
   logic        s_cm_valid, s_cm_ready, s_cm_insn3, s_cm_insn12, s_cm_insn13;
   logic [31:0] s_cm_rs1, s_cm_rs2, s_cm_dout_rd;
   logic        s_cm_dout_valid, s_cm_dout_ready;
   logic        s_out_valid, s_out_illegal;
   logic        s_out_ready = 1'b1;
   logic [31:0] s_out_rd;
   logic [4:0]  s_out_tag;

   rvb_clmul_dispatch #(.XLEN(64), .TAGW(5)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
      .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_rs1(cm_rs1), .cm_rs2(cm_rs2),
      .cm_insn3(cm_insn3), .cm_insn12(cm_insn12), .cm_insn13(cm_insn13),
      .cm_dout_valid(cm_dout_valid), .cm_dout_ready(cm_dout_ready), .cm_dout_rd(cm_dout_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_tag(out_tag), .out_illegal(out_illegal)
   );

   rvb_clmul #(.XLEN(64)) mul (
      .clock(clock), .reset(reset),
      .din_valid(cm_valid), .din_ready(cm_ready),
      .din_insn3(cm_insn3), .din_insn12(cm_insn12), .din_insn13(cm_insn13),
      .din_rs1(cm_rs1), .din_rs2(cm_rs2),
      .dout_valid(cm_dout_valid), .dout_ready(cm_dout_ready), .dout_rd(cm_dout_rd)
   );

   rvb_clmul_dispatch #(.XLEN(32), .TAGW(5)) dut32 (
      .clock(clock), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_insn(s_in_insn),
      .in_rs1(s_in_rs1), .in_rs2(s_in_rs2), .in_tag(s_in_tag),
      .cm_valid(s_cm_valid), .cm_ready(s_cm_ready), .cm_rs1(s_cm_rs1), .cm_rs2(s_cm_rs2),
      .cm_insn3(s_cm_insn3), .cm_insn12(s_cm_insn12), .cm_insn13(s_cm_insn13),
      .cm_dout_valid(s_cm_dout_valid), .cm_dout_ready(s_cm_dout_ready), .cm_dout_rd(s_cm_dout_rd),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_rd(s_out_rd),
      .out_tag(s_out_tag), .out_illegal(s_out_illegal)
   );

   rvb_clmul #(.XLEN(32)) mul32 (
      .clock(clock), .reset(reset),
      .din_valid(s_cm_valid), .din_ready(s_cm_ready),
      .din_insn3(s_cm_insn3), .din_insn12(s_cm_insn12), .din_insn13(s_cm_insn13),
      .din_rs1(s_cm_rs1), .din_rs2(s_cm_rs2),
      .dout_valid(s_cm_dout_valid), .dout_ready(s_cm_dout_ready), .dout_rd(s_cm_dout_rd)
   );

   typedef struct {
      logic [31:0] insn;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [4:0]  tag;
      logic [63:0] rd;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic push(input logic [31:0] insn, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [4:0] tag);
      int n = 0;
      in_valid = 1'b1;
      in_insn  = insn;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_tag   = tag;
      while (!in_ready && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         errors++;
         checks++;
         $display("FAIL push_timeout: got in_ready=0, expected 1 (tag %0d)", tag);
      end
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for out_valid, checks the result, completes the handshake.
   task automatic collect(input string name, input logic [4:0] tag, input logic [63:0] rd,
                          input logic ill, input int lat);
      int n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk({name, ".valid"}, {63'd0, out_valid}, 64'd1);
      if (lat > 0) chk({name, ".latency"}, 64'(n), 64'(lat));
      chk({name, ".rd"}, out_rd, rd);
      chk({name, ".tag"}, {59'd0, out_tag}, {59'd0, tag});
      chk({name, ".illegal"}, {63'd0, out_illegal}, {63'd0, ill});
      $display("%s: tag=%0d rd=0x%h illegal=%0d cycles=%0d", name, out_tag, out_rd, out_illegal, n);
      @(negedge clock);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int n;
      vecs[0]  = '{32'h0A2091B3, 64'd3, 64'd3, 5'd7, 64'd5, 1'b0, 10};
      vecs[1]  = '{32'h0A20B1B3, 64'h8000000000000000, 64'h8000000000000000, 5'd8, 64'h4000000000000000, 1'b0, 10};
      vecs[2]  = '{32'h0A20A1B3, 64'h8000000000000000, 64'd1, 5'd9, 64'd1, 1'b0, 10};
      vecs[3]  = '{32'h0A2091BB, 64'h80000000, 64'd1, 5'd10, 64'hFFFFFFFF80000000, 1'b0, 6};
      vecs[4]  = '{32'h0A2081B3, 64'd3, 64'd3, 5'd11, 64'd0, 1'b1, 1};
      vecs[5]  = '{32'h020091B3, 64'd3, 64'd3, 5'd12, 64'd0, 1'b1, 1};
      vecs[6]  = '{32'h0A2091B3, 64'd5, 64'd7, 5'd13, 64'h1B, 1'b0, 10};
      vecs[7]  = '{32'h0A20C1B3, 64'd5, 64'd7, 5'd14, 64'd0, 1'b1, 1};
      vecs[8]  = '{32'h0A20B1B3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd15, 64'h5555555555555555, 1'b0, 10};
      vecs[9]  = '{32'h0A20A1B3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd16, 64'hAAAAAAAAAAAAAAAA, 1'b0, 10};
      vecs[10] = '{32'h0A20B1BB, 64'h12345678FFFFFFFF, 64'hFFFFFFFF, 5'd17, 64'h0000000055555555, 1'b0, 6};
      vecs[11] = '{32'h0A20A1BB, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd18, 64'hFFFFFFFFAAAAAAAA, 1'b0, 6};
      vecs[12] = '{32'h0A209193, 64'd3, 64'd3, 5'd19, 64'd0, 1'b1, 1};
      vecs[13] = '{32'h0A20B1B3, 64'h100000000, 64'h100000000, 5'd20, 64'd1, 1'b0, 10};

      // Reset state
      repeat (3) @(negedge clock);
      chk("reset.in_ready", {63'd0, in_ready}, 64'd0);
      chk("reset.cm_valid", {63'd0, cm_valid}, 64'd0);
      chk("reset.cm_dout_ready", {63'd0, cm_dout_ready}, 64'd0);
      chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset.out_illegal", {63'd0, out_illegal}, 64'd0);
      chk("reset.s_in_ready", {63'd0, s_in_ready}, 64'd0);
      chk("reset.s_out_valid", {63'd0, s_out_valid}, 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle.cm_rs1", cm_rs1, 64'd0);
      chk("idle.in_ready", {63'd0, in_ready}, 64'd1);

      // Table of single transactions into an empty pipe
      for (int i = 0; i < 14; i++) begin
         push(vecs[i].insn, vecs[i].rs1, vecs[i].rs2, vecs[i].tag);
         chk($sformatf("vec%0d.cm_valid", i), {63'd0, cm_valid}, {63'd0, !vecs[i].ill});
         chk($sformatf("vec%0d.cm_rs1", i), cm_rs1, vecs[i].rs1);
         collect($sformatf("vec%0d", i), vecs[i].tag, vecs[i].rd, vecs[i].ill, vecs[i].lat);
         chk($sformatf("vec%0d.idle", i), {63'd0, out_valid}, 64'd0);
      end

      // Ordering: illegal behind a legal op must wait
      push(32'h0A2091B3, 64'd3, 64'd3, 5'd1);
      push(32'h0A2081B3, 64'd0, 64'd0, 5'd2);
      collect("order.first", 5'd1, 64'd5, 1'b0, -1);
      collect("order.second", 5'd2, 64'd0, 1'b1, 1);

      // Backpressure with three requests
      out_ready = 1'b0;
      push(32'h0A2091B3, 64'd5, 64'd7, 5'd10);
      push(32'h0A2081B3, 64'd0, 64'd0, 5'd11);
      push(32'h0A2091B3, 64'd3, 64'd3, 5'd12);
      chk("bp.in_ready_full", {63'd0, in_ready}, 64'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (i == 8) begin
            chk("bp.mid_valid", {63'd0, out_valid}, 64'd1);
            chk("bp.mid_rd", out_rd, 64'h1B);
            chk("bp.mid_tag", {59'd0, out_tag}, 64'd10);
         end
      end
      chk("bp.hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp.hold_rd", out_rd, 64'h1B);
      chk("bp.hold_tag", {59'd0, out_tag}, 64'd10);
      chk("bp.hold_dout_ready", {63'd0, cm_dout_ready}, 64'd0);
      chk("bp.hold_in_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      collect("bp.r0", 5'd10, 64'h1B, 1'b0, -1);
      collect("bp.r1", 5'd11, 64'd0, 1'b1, 1);
      collect("bp.r2", 5'd12, 64'd5, 1'b0, -1);

      // Reset three cycles after an issue
      push(32'h0A2091B3, 64'd3, 64'd3, 5'd9);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst.in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst.cm_valid", {63'd0, cm_valid}, 64'd0);
      chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst.cm_dout_ready", {63'd0, cm_dout_ready}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (15) begin
         @(negedge clock);
         if (out_valid || cm_valid) seen++;
      end
      chk("rst.no_spurious", 64'(seen), 64'd0);
      push(32'h0A2091B3, 64'd5, 64'd7, 5'd4);
      collect("rst.after", 5'd4, 64'h1B, 1'b0, 10);

      // XLEN=32 instance: W form is illegal, plain CLMUL takes 4 multiplier cycles
      s_in_valid = 1'b1;
      s_in_insn  = 32'h0A2091BB;
      s_in_rs1   = 32'h80000000;
      s_in_rs2   = 32'd1;
      s_in_tag   = 5'd3;
      chk("x32.in_ready", {63'd0, s_in_ready}, 64'd1);
      @(posedge clock);
      @(negedge clock);
      s_in_valid = 1'b0;
      chk("x32w.valid", {63'd0, s_out_valid}, 64'd1);
      chk("x32w.illegal", {63'd0, s_out_illegal}, 64'd1);
      chk("x32w.rd", {32'd0, s_out_rd}, 64'd0);
      chk("x32w.tag", {59'd0, s_out_tag}, 64'd3);
      chk("x32w.cm_valid", {63'd0, s_cm_valid}, 64'd0);
      $display("x32w: tag=%0d rd=0x%h illegal=%0d", s_out_tag, s_out_rd, s_out_illegal);
      @(negedge clock);
      s_in_valid = 1'b1;
      s_in_insn  = 32'h0A2091B3;
      s_in_rs1   = 32'h80000001;
      s_in_rs2   = 32'd3;
      s_in_tag   = 5'd6;
      @(posedge clock);
      @(negedge clock);
      s_in_valid = 1'b0;
      n = 1;
      while (!s_out_valid && n < 30) begin
         @(negedge clock);
         n++;
      end
      chk("x32.valid", {63'd0, s_out_valid}, 64'd1);
      chk("x32.latency", 64'(n), 64'd6);
      chk("x32.rd", {32'd0, s_out_rd}, 64'h80000003);
      chk("x32.tag", {59'd0, s_out_tag}, 64'd6);
      chk("x32.illegal", {63'd0, s_out_illegal}, 64'd0);
      $display("x32: tag=%0d rd=0x%h illegal=%0d cycles=%0d", s_out_tag, s_out_rd, s_out_illegal, n);
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvb_clmul_dispatch.md
# rvb_clmul_dispatch

Dispatch and result-tagging stage that sits directly upstream of the `rvb_clmul` carry-less multiply unit. It accepts full 32-bit instruction words with operands and a destination tag, and decodes the CLMUL family (CLMUL/CLMULR/CLMULH and their W forms). Legal ops go to the multiplier through a 2-entry input FIFO. Results are returned re-paired with their tag, and illegal encodings are reported in program order.

## Interface
- `XLEN`, 64, datapath width (32 or 64)
- `TAGW`, 5, tag width (destination register index)
- `clock`  in  1  positive-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted; 0 while reset is high
- `in_insn`  in  32  instruction word
- `in_rs1`, `in_rs2`  in  XLEN  operands
- `in_tag`  in  TAGW  destination tag
- `cm_valid`  out  1  drives multiplier `din_valid`
- `cm_ready`  in  1  from multiplier `din_ready`
- `cm_rs1`, `cm_rs2`  out  XLEN  multiplier operands
- `cm_insn3`, `cm_insn12`, `cm_insn13`  out  1  multiplier function-select bits
- `cm_dout_valid`  in  1  multiplier result valid
- `cm_dout_ready`  out  1  multiplier result accept
- `cm_dout_rd`  in  XLEN  multiplier result
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_rd`  out  XLEN  result value; 0 when illegal
- `out_tag`  out  TAGW  tag of the result
- `out_illegal`  out  1  instruction was not a legal CLMUL op

## Operation
- Decode: legal iff all of the following hold:
  - `insn[31:25]`=0000101
  - `insn[14:12]` ∈ {001, 010, 011}
  - `insn[6:0]`=0110011, or `insn[6:0]`=0111011 with XLEN=64
- Everything else is illegal. This includes W forms when XLEN=32.
- Decoded fields: insn3 = `insn[3]`, insn12 = `insn[12]`, insn13 = `insn[13]`.
- FIFO entry contents: {legal, insn3, insn12, insn13, rs1, rs2, tag}.
- Input FIFO: 2 entries, registered. `in_ready` = !full && !reset. A push and a pop in the same cycle are allowed when full.
- In-flight tracker: `pend` flag plus `pend_tag`. The multiplier holds at most one op.
- Issue (head legal):
  - `cm_valid` = !empty && head.legal.
  - On `cm_valid && cm_ready`: pop the head, set `pend`=1, `pend_tag`=head.tag.
- Result path (`pend`=1):
  - `out_valid` = `cm_dout_valid`, `out_rd` = `cm_dout_rd`, `out_tag` = `pend_tag`, `out_illegal`=0.
  - `cm_dout_ready` = `out_ready && pend`.
  - On accept, clear `pend`, unless a new issue happens in the same cycle. In that case `pend` stays 1 and `pend_tag` takes the new tag.
- Illegal retire (head illegal):
  - Waits until `pend`=0, which keeps program order.
  - Then `out_valid`=1, `out_rd`=0, `out_tag`=head.tag, `out_illegal`=1.
  - On `out_ready`: pop the head.
- Output priority: a pending multiplier result always wins over an illegal head.
- `cm_*` operand and select outputs are driven from the FIFO head whenever the FIFO is non-empty, and are 0 when it is empty.

## Timing
- Reset values (while `reset` is high):
  - `in_ready`=0, `cm_valid`=0, `cm_dout_ready`=0, `out_valid`=0, `out_illegal`=0.
  - FIFO empty, `pend`=0.
- Reset mid-operation drops FIFO contents and the pending tag. The multiplier is reset on the same `reset`, so no stale result can appear.
- Latency, legal op, empty pipe: accept at cycle 0 → `cm_valid` at cycle 1 → `out_valid` at 1+1+N cycles, where N = 4 (W forms or XLEN=32) or 8.
- Back-to-back: the next issue may coincide with the result handshake, because multiplier `din_ready` permits this. Throughput is one op per N+1 cycles.
- Latency, illegal op, empty pipe: `out_valid` 1 cycle after accept.
- All outputs are combinational from registered state plus `cm_ready`, `cm_dout_valid` and `out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- `out_*` hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `rvb_pkg`:
  - opcode constants `OPC_OP`=0110011 and `OPC_OP32`=0111011
  - `F7_CLMUL`=0000101
  - funct3 constants for CLMUL, CLMULR and CLMULH
  - the FIFO-entry struct typedef
- Sub-module: `rvb_fifo2`, a generic 2-entry valid/ready FIFO parameterised on entry width, reused by other bitmanip dispatch stages.
- Top-level file instantiates `rvb_fifo2` and contains the decoder, tracker and output mux. The bench instantiates the top-level file together with the `rvb_clmul` multiplier.

## Test plan
- XLEN=64: CLMUL (`insn` 0x0A2091B3), rs1=3, rs2=3, tag=7 → `out_rd`=5, `out_tag`=7, `out_illegal`=0, `out_valid` 10 cycles after accept.
- XLEN=64: CLMULH, rs1=rs2=0x8000000000000000 → `out_rd`=0x4000000000000000. CLMULR, rs1=0x8000000000000000, rs2=1 → `out_rd`=1.
- XLEN=64: CLMULW (opcode 0111011), rs1=0x80000000, rs2=1 → `out_rd`=0xFFFFFFFF80000000 after 4 multiplier cycles. Same insn with XLEN=32 → `out_illegal`=1, `out_rd`=0.
- Ordering: legal tag 1 followed by funct3=000 tag 2 → tag 1 result first, then illegal tag 2; the illegal op never overtakes the legal one.
- Backpressure: `out_ready`=0 for 20 cycles with 3 requests offered → `in_ready` drops after the FIFO fills, output holds stable, all 3 results retire in order once `out_ready`=1.
- Reset asserted 3 cycles after a CLMUL issue → all valids 0 during and after reset, no spurious result. The next CLMUL (tag 4) returns the correct value.
